// File: rtl/q_layer_seq.sv
// Sequenced Twofish q0/q1 byte-permutation layer behind a valid/ready handshake.
// Define Q_LAYER_SEQ_PARALLEL_EN for four parallel q0/q1 lanes (one-cycle RUN).
module q_layer_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_word,
  input  logic [3:0]  in_sel,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_word,
  output logic        busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  // Nibble S-box tables, entry 0 in the most significant nibble.
  localparam logic [63:0] Q0_T0 = 64'h817D6F320B59ECA4;
  localparam logic [63:0] Q0_T1 = 64'hECB81235F4A6709D;
  localparam logic [63:0] Q0_T2 = 64'hBA5E6D90C8F32471;
  localparam logic [63:0] Q0_T3 = 64'hD7F4126E9B3085CA;
  localparam logic [63:0] Q1_T0 = 64'h28BDF76E31940AC5;
  localparam logic [63:0] Q1_T1 = 64'h1E2B4C376DA5F908;
  localparam logic [63:0] Q1_T2 = 64'h4C75169A0ED82B3F;
  localparam logic [63:0] Q1_T3 = 64'hB951C3DE647F208A;

  function automatic logic [3:0] tlk(input logic [63:0] t, input logic [3:0] i);
    return t[(15 - int'(i)) * 4 +: 4];
  endfunction

  function automatic logic [7:0] qperm(input logic [7:0] x,
                                       input logic [63:0] t0, input logic [63:0] t1,
                                       input logic [63:0] t2, input logic [63:0] t3);
    logic [3:0] a0, b0, a1, b1, a2, b2, a3, b3, a4, b4;
    a0 = x[7:4];
    b0 = x[3:0];
    a1 = a0 ^ b0;
    b1 = a0 ^ {b0[0], b0[3:1]} ^ {a0[0], 3'b000};
    a2 = tlk(t0, a1);
    b2 = tlk(t1, b1);
    a3 = a2 ^ b2;
    b3 = a2 ^ {b2[0], b2[3:1]} ^ {a2[0], 3'b000};
    a4 = tlk(t2, a3);
    b4 = tlk(t3, b3);
    return {b4, a4};
  endfunction

  function automatic logic [7:0] q0(input logic [7:0] x);
    return qperm(x, Q0_T0, Q0_T1, Q0_T2, Q0_T3);
  endfunction

  function automatic logic [7:0] q1(input logic [7:0] x);
    return qperm(x, Q1_T0, Q1_T1, Q1_T2, Q1_T3);
  endfunction

  logic [1:0]  state;
  logic [1:0]  cnt;
  logic [31:0] word_r;
  logic [3:0]  sel_r;
  logic [31:0] result;

`ifdef Q_LAYER_SEQ_PARALLEL_EN
  logic [31:0] par_q;
  for (genvar i = 0; i < 4; i++) begin : g_lane
    assign par_q[8*i +: 8] = sel_r[i] ? q1(word_r[8*i +: 8]) : q0(word_r[8*i +: 8]);
  end
`else
  // One shared q0/q1 pair; the lane is picked purely from registered cnt/sel_r.
  logic [7:0] lane_byte;
  logic [7:0] lane_q;
  assign lane_byte = word_r[{cnt, 3'b000} +: 8];
  assign lane_q    = sel_r[cnt] ? q1(lane_byte) : q0(lane_byte);
`endif

  // NOTE: every register here, including the result word, sits on the async
  // reset so an aborted request can never leak stale bytes; use <= only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= 2'd0;
      word_r <= 32'd0;
      sel_r  <= 4'd0;
      result <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            word_r <= in_word;
            sel_r  <= in_sel;
            result <= 32'd0;
            cnt    <= 2'd0;
            state  <= RUN;
          end
        end
        RUN: begin
`ifdef Q_LAYER_SEQ_PARALLEL_EN
          result <= par_q;
          state  <= DONE;
`else
          result[{cnt, 3'b000} +: 8] <= lane_q;
          cnt <= cnt + 2'd1;
          if (cnt == 2'd3) state <= DONE;
`endif
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign out_word  = result;

endmodule

// File: tb/tb_q_layer_seq.sv
// Self-checking bench for q_layer_seq: latency-level reference model plus
// directed Twofish q-vector, backpressure, reset and randomized traffic.
module tb_q_layer_seq;

`ifdef Q_LAYER_SEQ_PARALLEL_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 4;
`endif
  localparam int PER = LAT + 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_word;
  logic [3:0]  in_sel;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_word;
  logic        busy;

  q_layer_seq dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_word(in_word), .in_sel(in_sel),
    .out_valid(out_valid), .out_ready(out_ready), .out_word(out_word),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int dut_acc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Twofish q permutations as 256-entry tables built from the nibble S-boxes.
  int q0_t0[16] = '{8,1,7,13,6,15,3,2,0,11,5,9,14,12,10,4};
  int q0_t1[16] = '{14,12,11,8,1,2,3,5,15,4,10,6,7,0,9,13};
  int q0_t2[16] = '{11,10,5,14,6,13,9,0,12,8,15,3,2,4,7,1};
  int q0_t3[16] = '{13,7,15,4,1,2,6,14,9,11,3,0,8,5,12,10};
  int q1_t0[16] = '{2,8,11,13,15,7,6,14,3,1,9,4,0,10,12,5};
  int q1_t1[16] = '{1,14,2,11,4,12,3,7,6,13,10,5,15,9,0,8};
  int q1_t2[16] = '{4,12,7,5,1,6,9,10,0,14,13,8,2,11,3,15};
  int q1_t3[16] = '{11,9,5,1,12,3,13,14,6,4,7,15,2,0,8,10};
  int q0_tab[256];
  int q1_tab[256];

  function automatic int ror4(input int v);
    return ((v >> 1) | (v << 3)) & 15;
  endfunction

  function automatic int qcalc(input int x, input int t0[16], input int t1[16],
                               input int t2[16], input int t3[16]);
    int a, b, a2, b2;
    a  = x / 16;
    b  = x % 16;
    a2 = t0[a ^ b];
    b2 = t1[a ^ ror4(b) ^ ((8 * a) % 16)];
    a  = t2[a2 ^ b2];
    b  = t3[a2 ^ ror4(b2) ^ ((8 * a2) % 16)];
    return 16 * b + a;
  endfunction

  function automatic logic [31:0] exp_word(input logic [31:0] w, input logic [3:0] s);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 4; i++)
      r[8*i +: 8] = 8'(s[i] ? q1_tab[w[8*i +: 8]] : q0_tab[w[8*i +: 8]]);
    return r;
  endfunction

  // Reference model: a request becomes visible LAT edges after acceptance.
  logic        m_busy, m_done;
  int          m_left;
  logic [31:0] m_res;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 1'b0; m_done = 1'b0; m_left = 0; m_res = '0;
    end else if (!m_busy) begin
      if (in_valid) begin
        m_busy = 1'b1;
        m_left = LAT;
        m_res  = exp_word(in_word, in_sel);
      end
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) m_done = 1'b1;
    end else if (m_done && out_ready) begin
      m_done = 1'b0;
      m_busy = 1'b0;
    end
  end

  always @(negedge clk) begin
    check("in_ready", 32'(in_ready), 32'(!m_busy));
    check("busy", 32'(busy), 32'(m_busy));
    check("out_valid", 32'(out_valid), 32'(m_done));
    if (m_done) check("out_word", out_word, m_res);
    if (rst_n && in_valid && in_ready) dut_acc++;
  end

  task automatic check_reset_values();
    check("rst in_ready", 32'(in_ready), 32'd1);
    check("rst out_valid", 32'(out_valid), 32'd0);
    check("rst out_word", out_word, 32'd0);
    check("rst busy", 32'(busy), 32'd0);
  endtask

  task automatic wait_ready();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 40);
    if (!in_ready) check("wait_ready timeout", 32'(in_ready), 32'd1);
  endtask

  // Returns edges counted from the accept edge until out_valid is seen.
  task automatic wait_valid(output int cyc);
    cyc = 0;
    do begin
      @(posedge clk);
      #1;
      cyc++;
    end while (!out_valid && cyc < 40);
    if (!out_valid) check("wait_valid timeout", 32'(out_valid), 32'd1);
  endtask

  task automatic run_vec(input logic [31:0] w, input logic [3:0] s,
                         input logic [31:0] expect_w, input bit toggle, input string name);
    int cyc;
    @(posedge clk); #1;
    in_valid = 1'b1; in_word = w; in_sel = s; out_ready = 1'b1;
    wait_ready();
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (toggle) begin
      in_word = 32'hFFFFFFFF;
      in_sel  = ~s;
    end
    wait_valid(cyc);
    check({name, " latency"}, 32'(cyc), 32'(LAT));
    check({name, " word"}, out_word, expect_w);
    @(posedge clk); #1;
  endtask

  initial begin
    int cyc, acc0;
    logic [31:0] held;

    for (int x = 0; x < 256; x++) begin
      q0_tab[x] = qcalc(x, q0_t0, q0_t1, q0_t2, q0_t3);
      q1_tab[x] = qcalc(x, q1_t0, q1_t1, q1_t2, q1_t3);
    end
    check("model q0 vec", exp_word(32'h03020100, 4'b0000), 32'hE8B367A9);
    check("model q1 vec", exp_word(32'h03020100, 4'b1111), 32'hF4C6F375);

    rst_n = 1'b0; in_valid = 1'b0; in_word = '0; in_sel = '0; out_ready = 1'b0;
    #1;
    check_reset_values();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_values();

    run_vec(32'h03020100, 4'b0000, 32'hE8B367A9, 1'b0, "q0 all");
    run_vec(32'h03020100, 4'b1111, 32'hF4C6F375, 1'b0, "q1 all");
    run_vec(32'h03020100, 4'b0101, 32'hE8C66775, 1'b1, "mixed toggle");

    // Backpressure with a second request waiting the whole time.
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b1; in_word = 32'hDEADBEEF; in_sel = 4'b1010;
    wait_ready();
    @(posedge clk); #1;
    in_word = 32'h12345678; in_sel = 4'b0110;
    wait_valid(cyc);
    held = out_word;
    check("bp first word", held, 32'(exp_word(32'hDEADBEEF, 4'b1010)));
    acc0 = dut_acc;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp stable", out_word, held);
      check("bp in_ready low", 32'(in_ready), 32'd0);
      check("bp out_valid held", 32'(out_valid), 32'd1);
    end
    check("bp no second accept", 32'(dut_acc), 32'(acc0));
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp idle after handshake", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    check("bp second accepted", 32'(busy), 32'd1);
    in_valid = 1'b0;
    wait_valid(cyc);
    check("bp second latency", 32'(cyc), 32'(LAT));
    check("bp second word", out_word, 32'(exp_word(32'h12345678, 4'b0110)));
    @(posedge clk); #1;

    // Back-to-back throughput: PER*5 edges hold exactly five accepts.
    acc0 = dut_acc;
    in_valid = 1'b1; in_word = 32'hA5A55A5A; in_sel = 4'b0011; out_ready = 1'b1;
    repeat (PER * 5) @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("throughput accepts", 32'(dut_acc - acc0), 32'd5);
    repeat (PER + 2) @(posedge clk);
    #1;

    // Reset in the middle of RUN (after E2).
    in_valid = 1'b1; in_word = 32'h0F1E2D3C; in_sel = 4'b1001;
    wait_ready();
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check_reset_values();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("no valid after reset", 32'(out_valid), 32'd0);
    end

    // Randomized traffic; the per-cycle compare process does the checking.
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      in_valid  = 1'($urandom_range(0, 1));
      in_word   = $urandom;
      in_sel    = 4'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (PER + 2) @(posedge clk);
    #1;
    check("drained idle", 32'(in_ready), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
